// File: rtl/const_bank.sv
// const_bank: serially loaded bank of WIDTH constant drivers with atomic commit.
// Optional define CONST_BANK_PARITY_EN adds the cfg_parity port and commit check.
module const_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             prog_clk,
    input  logic             prog_rst_n,
    input  logic             ccff_head,
    output logic             ccff_tail,
    input  logic             cfg_en,
    input  logic             cfg_commit,
`ifdef CONST_BANK_PARITY_EN
    input  logic             cfg_parity,
`endif
    output logic [WIDTH-1:0] const_out,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL,
        OVER
    } state_t;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_next;
    logic [WIDTH-1:0] const_next;
    logic             done_next;
    logic             err_next;
    logic             shift;
    logic             parity_ok;
    state_t           state;

    // The counter is the state register; the state is a decode of it.
    always_comb begin
        state = OVER;
        if (cnt == '0)
            state = EMPTY;
        else if (cnt < CW'(WIDTH))
            state = PARTIAL;
        else if (cnt == CW'(WIDTH))
            state = FULL;
    end

`ifdef CONST_BANK_PARITY_EN
    assign parity_ok = ((^shadow) == cfg_parity);
`else
    assign parity_ok = 1'b1;
`endif

    // Commit has priority: a shift in the commit cycle is dropped.
    assign shift = cfg_en & ~cfg_commit;

    always_comb begin
        cnt_next    = cnt;
        shadow_next = shadow;
        const_next  = const_out;
        done_next   = 1'b0;
        err_next    = 1'b0;
        if (cfg_commit) begin
            cnt_next = '0;
            if (state == FULL && parity_ok) begin
                const_next = shadow;
                done_next  = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (shift) begin
            shadow_next = WIDTH'({ccff_head, shadow} >> 1);
            if (state != OVER)
                cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            cnt       <= '0;
            shadow    <= RESET_VALUE;
            const_out <= RESET_VALUE;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            shadow    <= shadow_next;
            const_out <= const_next;
            cfg_done  <= done_next;
            cfg_err   <= err_next;
        end
    end

    assign ccff_tail = shadow[0];

endmodule
